// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the DDS PLL reconfiguration controller and its scan responder.
// State encoding is fixed so both sides of the handshake can decode it consistently.
package pll_reconfig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_UPDATE    = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    localparam int DEFAULT_CHAIN_LEN = 144;
    localparam int DEFAULT_TIMEOUT   = 1023;
    localparam int DEFAULT_CNT_W     = 10;

endpackage

// File: rtl/pll_scan_responder_if.sv
// Request/status and PLL scan signals of the reconfiguration responder.
// The master side is the environment (controller plus PLL); the slave side is the responder.
interface pll_scan_responder_if
    import pll_reconfig_pkg::*;
#(
    parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN
);
    logic                 write_param;
    logic                 reconfig;
    logic [CHAIN_LEN-1:0] param_data;
    logic                 busy;
    logic                 scanclkena;
    logic                 scandata;
    logic                 configupdate;
    logic                 scandone;
    logic                 error;

    modport master (
        output write_param, reconfig, param_data, scandone,
        input  busy, scanclkena, scandata, configupdate, error
    );

    modport slave (
        input  write_param, reconfig, param_data, scandone,
        output busy, scanclkena, scandata, configupdate, error
    );
endinterface

// File: rtl/pll_scan_shifter.sv
// Shadow register plus parallel-in/serial-out scan shifter, MSB first.
// A working copy is shifted so the shadow image survives for a repeated reconfig.
module pll_scan_shifter
    import pll_reconfig_pkg::*;
#(
    parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 start,
    input  logic                 shift_en,
    input  logic [CHAIN_LEN-1:0] param_data,
    output logic                 last_bit,
    output logic                 scandata,
    output logic                 scanclkena
);
    logic [CHAIN_LEN-1:0] shadow;
    logic [CHAIN_LEN-1:0] work;
    logic [CNT_W-1:0]     cnt;

    assign last_bit = (cnt == CNT_W'(CHAIN_LEN - 1));

    // NOTE: the shadow image is an ordinary register, so it takes the async reset like every other flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow     <= '0;
            work       <= '0;
            cnt        <= '0;
            scandata   <= 1'b0;
            scanclkena <= 1'b0;
        end else begin
            if (load) begin
                shadow <= param_data;
            end
            if (start) begin
                // First bit is presented straight from the shadow; the rest come from the working copy.
                scandata   <= shadow[CHAIN_LEN-1];
                scanclkena <= 1'b1;
                work       <= shadow << 1;
                cnt        <= '0;
            end else if (shift_en) begin
                if (last_bit) begin
                    scandata   <= 1'b0;
                    scanclkena <= 1'b0;
                end else begin
                    scandata <= work[CHAIN_LEN-1];
                    work     <= work << 1;
                    cnt      <= cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: rtl/pll_scan_responder.sv
// Responder for the PLL reconfiguration handshake: latches an image, scans it into the PLL,
// strobes configupdate and waits for scandone with a timeout that sets a sticky error.
module pll_scan_responder
    import pll_reconfig_pkg::*;
#(
    parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input logic                  clk,
    input logic                  reset,
    pll_scan_responder_if.slave  pll
);
    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] tcnt;
    logic             accept_write;
    logic             accept_reconfig;
    logic             timeout_hit;
    logic             last_bit;
    logic             busy_q;
    logic             configupdate_q;
    logic             error_q;

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        next_state      = state;
        accept_write    = 1'b0;
        accept_reconfig = 1'b0;
        timeout_hit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pll.write_param) begin
                    accept_write = 1'b1;
                    next_state   = ST_LOAD;
                end else if (pll.reconfig) begin
                    accept_reconfig = 1'b1;
                    next_state      = ST_SHIFT;
                end
            end
            ST_LOAD:   next_state = ST_IDLE;
            ST_SHIFT:  if (last_bit) next_state = ST_UPDATE;
            ST_UPDATE: next_state = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (pll.scandone) begin
                    next_state = ST_IDLE;
                end else if (tcnt == CNT_W'(TIMEOUT)) begin
                    timeout_hit = 1'b1;
                    next_state  = ST_IDLE;
                end
            end
            default:   next_state = ST_IDLE;
        endcase
    end

    // Status outputs are registered from next_state so they align with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            tcnt           <= '0;
            busy_q         <= 1'b0;
            configupdate_q <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state          <= next_state;
            busy_q         <= (next_state != ST_IDLE);
            configupdate_q <= (next_state == ST_UPDATE);
            if (state == ST_UPDATE) begin
                tcnt <= '0;
            end else if (state == ST_WAIT_DONE) begin
                tcnt <= tcnt + CNT_W'(1);
            end
            if (accept_write) begin
                error_q <= 1'b0;
            end else if (timeout_hit) begin
                error_q <= 1'b1;
            end
        end
    end

    assign pll.busy         = busy_q;
    assign pll.configupdate = configupdate_q;
    assign pll.error        = error_q;

    pll_scan_shifter #(
        .CHAIN_LEN (CHAIN_LEN),
        .CNT_W     (CNT_W)
    ) u_shifter (
        .clk        (clk),
        .reset      (reset),
        .load       (accept_write),
        .start      (accept_reconfig),
        .shift_en   (state == ST_SHIFT),
        .param_data (pll.param_data),
        .last_bit   (last_bit),
        .scandata   (pll.scandata),
        .scanclkena (pll.scanclkena)
    );
endmodule

// File: tb/tb_pll_scan_responder.sv
// Scoreboard bench for pll_scan_responder: the driver pushes expected scan bits, update strobes
// and transaction summaries; an independent monitor pops and compares as the DUT produces them.
module tb_pll_scan_responder;
    localparam int CL = 8;
    localparam int TO = 15;
    localparam int CW = 5;

    typedef struct {
        int len;
        bit err;
    } txn_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pll_scan_responder_if #(.CHAIN_LEN(CL)) pll();

    pll_scan_responder #(
        .CHAIN_LEN (CL),
        .TIMEOUT   (TO),
        .CNT_W     (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pll   (pll)
    );

    txn_t txn_q[$];
    bit   bit_q[$];
    bit   cfg_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [CL-1:0] m_shadow = '0;
    bit            m_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin : monitor
        int   busy_cnt;
        bit   prev_ena;
        logic prev_busy;
        busy_cnt  = 0;
        prev_ena  = 1'b0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_cnt  = 0;
                prev_ena  = 1'b0;
                prev_busy = 1'b0;
                continue;
            end
            if (pll.scanclkena) begin
                check("scan_bit_expected", 32'(bit_q.size() != 0), 1);
                if (bit_q.size() != 0) begin
                    bit exp_b;
                    exp_b = bit_q.pop_front();
                    check("scandata", 32'(pll.scandata), 32'(exp_b));
                end
            end
            if (pll.configupdate) begin
                check("cfg_after_last_bit", 32'(prev_ena), 1);
                check("cfg_expected", 32'(cfg_q.size() != 0), 1);
                if (cfg_q.size() != 0) begin
                    void'(cfg_q.pop_front());
                    check("bits_left_at_update", bit_q.size(), 0);
                end
            end
            if (pll.busy) begin
                busy_cnt++;
            end else if (prev_busy) begin
                check("txn_expected", 32'(txn_q.size() != 0), 1);
                if (txn_q.size() != 0) begin
                    txn_t t;
                    t = txn_q.pop_front();
                    check("busy_len", busy_cnt, t.len);
                    check("error", 32'(pll.error), 32'(t.err));
                end
                busy_cnt = 0;
            end
            prev_ena  = pll.scanclkena;
            prev_busy = pll.busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (pll.busy && k < 100) begin
            tick();
            k++;
        end
        check("idle_within_budget", 32'(pll.busy), 0);
    endtask

    task automatic do_write(input logic [CL-1:0] data, input bit both);
        m_shadow = data;
        m_err    = 1'b0;
        txn_q.push_back('{len: 1, err: 1'b0});
        pll.param_data  = data;
        pll.write_param = 1'b1;
        pll.reconfig    = both;
        tick();
        pll.write_param = 1'b0;
        pll.reconfig    = 1'b0;
        check("busy_after_write", 32'(pll.busy), 1);
        wait_idle();
    endtask

    // d = WAIT_DONE cycles with scandone low before it rises; d > TO means it never rises.
    task automatic do_reconfig(input int d, input bit junk, input bit inject);
        int w;
        int k;
        w = (d > TO) ? TO + 1 : d + 1;
        for (int i = 0; i < CL; i++) bit_q.push_back(m_shadow[CL-1-i]);
        cfg_q.push_back(1'b1);
        if (d > TO) m_err = 1'b1;
        txn_q.push_back('{len: CL + 1 + w, err: m_err});
        pll.reconfig = 1'b1;
        tick();
        pll.reconfig = 1'b0;
        check("busy_after_reconfig", 32'(pll.busy), 1);
        if (junk) pll.scandone = 1'b1;
        if (inject) begin
            tick();
            pll.param_data  = {CL{1'b1}};
            pll.write_param = 1'b1;
            tick();
            pll.write_param = 1'b0;
        end
        k = 0;
        while (!pll.configupdate && k < 50) begin
            tick();
            k++;
        end
        check("configupdate_seen", 32'(pll.configupdate), 1);
        pll.scandone = (d == 0);
        for (int j = 1; j < 40; j++) begin
            tick();
            if (!pll.busy) break;
            pll.scandone = (j - 1 >= d);
        end
        pll.scandone = 1'b0;
        wait_idle();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 32'(pll.busy), 0);
        check({tag, "_scanclkena"}, 32'(pll.scanclkena), 0);
        check({tag, "_scandata"}, 32'(pll.scandata), 0);
        check({tag, "_configupdate"}, 32'(pll.configupdate), 0);
        check({tag, "_error"}, 32'(pll.error), 0);
    endtask

    task automatic abort_mid_shift();
        int k;
        do_write(8'($urandom), 1'b0);
        for (int i = 0; i < CL; i++) bit_q.push_back(m_shadow[CL-1-i]);
        cfg_q.push_back(1'b1);
        txn_q.push_back('{len: 0, err: 1'b0});
        pll.reconfig = 1'b1;
        tick();
        pll.reconfig = 1'b0;
        k = 0;
        while (bit_q.size() > CL - 4 && k < 30) begin
            tick();
            k++;
        end
        check("abort_reached_bit4", bit_q.size(), CL - 4);
        check("abort_shifting", 32'(pll.scanclkena), 1);
        #3;
        reset = 1'b1;
        bit_q.delete();
        cfg_q.delete();
        txn_q.delete();
        m_shadow = '0;
        m_err    = 1'b0;
        #1;
        check_outputs_zero("abort");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) begin
            tick();
            check("abort_stays_idle", 32'(pll.busy), 0);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        pll.write_param = 1'b0;
        pll.reconfig    = 1'b0;
        pll.param_data  = '0;
        pll.scandone    = 1'b0;
        #1;
        check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tick();
        check_outputs_zero("post_reset");

        do_write(8'hA5, 1'b0);
        do_reconfig(0, 1'b0, 1'b0);

        do_write(8'h3C, 1'b1);
        do_reconfig(2, 1'b1, 1'b0);

        do_reconfig(99, 1'b0, 1'b0);
        do_reconfig(1, 1'b0, 1'b0);
        do_write(8'h5A, 1'b0);

        do_write(8'h0F, 1'b0);
        do_reconfig(0, 1'b0, 1'b1);
        do_reconfig(3, 1'b0, 1'b0);

        do_reconfig(TO, 1'b0, 1'b0);
        do_reconfig(TO + 1, 1'b1, 1'b0);

        abort_mid_shift();
        do_write(8'hC3, 1'b0);
        do_reconfig(4, 1'b0, 1'b0);

        for (int it = 0; it < 30; it++) begin
            int op;
            op = int'($urandom_range(0, 3));
            if (op == 0) do_write(8'($urandom), 1'b0);
            else if (op == 1) do_write(8'($urandom), 1'b1);
            else do_reconfig(int'($urandom_range(0, 20)), 1'($urandom), 1'($urandom));
            repeat (int'($urandom_range(0, 3))) tick();
        end

        repeat (3) tick();
        check("txn_q_drained", txn_q.size(), 0);
        check("bit_q_drained", bit_q.size(), 0);
        check("cfg_q_drained", cfg_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
